// File: rtl/fdivsqrt_otfc_pkg.sv
// Shared definitions for the radix-4 on-the-fly conversion accumulator:
// one-hot digit encodings, FSM state type and the illegal-digit check.
// Optional feature macro (used by the top): FDIVSQRT_EARLY_TERM_EN.
package fdivsqrt_otfc_pkg;

   localparam logic [3:0] DIG_P2 = 4'b1000;
   localparam logic [3:0] DIG_P1 = 4'b0100;
   localparam logic [3:0] DIG_M1 = 4'b0010;
   localparam logic [3:0] DIG_M2 = 4'b0001;
   localparam logic [3:0] DIG_Z  = 4'b0000;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACCUM = 2'b01,
      PAD   = 2'b10,
      DONE  = 2'b11
   } otfc_state_t;

   // A digit is illegal when more than one bit is hot, or when the very
   // first digit of an operation is negative (the result would go below zero).
   function automatic logic digit_illegal(input logic [3:0] digit, input logic first);
      logic multi_hot;
      logic negative;
      multi_hot = ((digit & (digit - 4'b0001)) != 4'b0000);
      negative  = (digit == DIG_M1) || (digit == DIG_M2);
      return multi_hot || (first && negative);
   endfunction

endpackage

// File: rtl/fdivsqrt_otfc4_step.sv
// One radix-4 on-the-fly conversion step: shifts U/UM left by one digit and
// appends the new digit without any carry-propagate addition. Negative digits
// take their prefix from UM (the borrow is already folded into it).
module fdivsqrt_otfc4_step
   import fdivsqrt_otfc_pkg::*;
#(
   parameter int W = 6
) (
   input  logic [W-1:0] u,
   input  logic [W-1:0] um,
   input  logic [3:0]   udigit,
   output logic [W-1:0] unext,
   output logic [W-1:0] umnext
);

   // Select the new U/UM pair for the incoming digit; unknown codes act as 0.
   always_comb begin
      unext  = {u[W-3:0], 2'b00};
      umnext = {um[W-3:0], 2'b11};
      case (udigit)
         DIG_P2: begin
            unext  = {u[W-3:0], 2'b10};
            umnext = {u[W-3:0], 2'b01};
         end
         DIG_P1: begin
            unext  = {u[W-3:0], 2'b01};
            umnext = {u[W-3:0], 2'b00};
         end
         DIG_M1: begin
            unext  = {um[W-3:0], 2'b11};
            umnext = {um[W-3:0], 2'b10};
         end
         DIG_M2: begin
            unext  = {um[W-3:0], 2'b10};
            umnext = {um[W-3:0], 2'b01};
         end
         DIG_Z: begin
            unext  = {u[W-3:0], 2'b00};
            umnext = {um[W-3:0], 2'b11};
         end
         default: begin
            unext  = {u[W-3:0], 2'b00};
            umnext = {um[W-3:0], 2'b11};
         end
      endcase
   end

endmodule

// File: rtl/fdivsqrt_otfc4_accum.sv
// Radix-4 digit accumulator: collects NDIG one-hot quotient/root digits,
// converts them on the fly into U and UM = U - 1 ulp, and hands the pair
// downstream over a valid/ready port.
// Optional feature macro: FDIVSQRT_EARLY_TERM_EN -- when defined, ResZero ends
// digit intake early and the remaining digits are padded with zeros (PAD state).
module fdivsqrt_otfc4_accum
   import fdivsqrt_otfc_pkg::*;
#(
   parameter  int DIVb = 56,
   localparam int NDIG = (DIVb + 3) / 2,
   localparam int W    = 2 * NDIG,
   localparam int CNTW = $clog2(NDIG + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         Start,
   input  logic         DigitValid,
   input  logic [3:0]   UDigit,
   input  logic         ResZero,
   output logic         DigitReady,
   output logic         QValid,
   input  logic         QReady,
   output logic [W-1:0] U,
   output logic [W-1:0] UM,
   output logic         DigitErr
);

   otfc_state_t     state_r, state_s;
   logic [W-1:0]    u_r, u_s, um_r, um_s;
   logic [CNTW-1:0] count_r, count_s;
   logic            err_r, err_s;
   logic            qvalid_r, dready_r;
   logic            accept_s, illegal_s;
   logic [3:0]      step_digit_s;
   logic [W-1:0]    step_u_s, step_um_s;
   logic            last_s, early_s;

`ifndef FDIVSQRT_EARLY_TERM_EN
   logic unused_reszero_s;
   assign unused_reszero_s = ResZero;
`endif

   // Qualify the incoming digit and pick what the shared step unit converts.
   always_comb begin
      accept_s     = (state_r == ACCUM) && DigitValid;
      illegal_s    = digit_illegal(UDigit, (count_r == {CNTW{1'b0}}));
      last_s       = (count_r == CNTW'(NDIG - 1));
      step_digit_s = DIG_Z;
      if (accept_s && !illegal_s) begin
         step_digit_s = UDigit;
      end else begin
         step_digit_s = DIG_Z;
      end
`ifdef FDIVSQRT_EARLY_TERM_EN
      early_s = ResZero;
`else
      early_s = 1'b0;
`endif
   end

   fdivsqrt_otfc4_step #(.W(W)) u_step (
      .u      (u_r),
      .um     (um_r),
      .udigit (step_digit_s),
      .unext  (step_u_s),
      .umnext (step_um_s)
   );

   // Next-state and datapath update; Start overrides every other event.
   always_comb begin
      state_s = state_r;
      u_s     = u_r;
      um_s    = um_r;
      count_s = count_r;
      err_s   = err_r;
      if (Start) begin
         state_s = ACCUM;
         u_s     = {W{1'b0}};
         um_s    = {W{1'b0}};
         count_s = {CNTW{1'b0}};
         err_s   = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               state_s = IDLE;
            end
            ACCUM: begin
               if (accept_s) begin
                  u_s     = step_u_s;
                  um_s    = step_um_s;
                  count_s = count_r + CNTW'(1);
                  err_s   = err_r || illegal_s;
                  if (last_s) begin
                     state_s = DONE;
                  end else if (early_s) begin
                     state_s = PAD;
                  end else begin
                     state_s = ACCUM;
                  end
               end else begin
                  state_s = ACCUM;
               end
            end
`ifdef FDIVSQRT_EARLY_TERM_EN
            PAD: begin
               u_s     = step_u_s;
               um_s    = step_um_s;
               count_s = count_r + CNTW'(1);
               if (last_s) begin
                  state_s = DONE;
               end else begin
                  state_s = PAD;
               end
            end
`endif
            DONE: begin
               if (QReady) begin
                  state_s = IDLE;
               end else begin
                  state_s = DONE;
               end
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end
   end

   // State, datapath and registered status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= IDLE;
         u_r      <= {W{1'b0}};
         um_r     <= {W{1'b0}};
         count_r  <= {CNTW{1'b0}};
         err_r    <= 1'b0;
         qvalid_r <= 1'b0;
         dready_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         u_r      <= u_s;
         um_r     <= um_s;
         count_r  <= count_s;
         err_r    <= err_s;
         qvalid_r <= (state_s == DONE);
         dready_r <= (state_s == ACCUM);
      end
   end

   assign U          = u_r;
   assign UM         = um_r;
   assign QValid     = qvalid_r;
   assign DigitReady = dready_r;
   assign DigitErr   = err_r;

endmodule
